// File: rtl/prn_pkg.sv
// Shared types, constants and the xorshift step for the PRN sequence generator.
package prn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } prn_state_e;

  localparam logic [63:0] DEFAULT_SEED = 64'h0000_0000_ACE1_ACE1;

  localparam int unsigned SHIFT_A = 13;
  localparam int unsigned SHIFT_B = 7;
  localparam int unsigned SHIFT_C = 17;

  // One xorshift step on the low w bits (w = 32 or 64); upper bits are returned as zero.
  function automatic logic [63:0] xorshift_step(input logic [63:0] s, input int unsigned w);
    logic [63:0] mask;
    logic [63:0] x;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    x = s & mask;
    x = (x ^ (x << SHIFT_A)) & mask;
    x = x ^ (x >> SHIFT_B);
    x = (x ^ (x << SHIFT_C)) & mask;
    return x;
  endfunction

endpackage

// File: rtl/prn_mod_reduce.sv
// Combinational exact reduction of a STATE_W-bit value modulo m, where m = 0 encodes 2^OUT_W.
module prn_mod_reduce
  import prn_pkg::*;
#(
  parameter int unsigned STATE_W = 32,
  parameter int unsigned OUT_W   = 4
) (
  input  logic [STATE_W-1:0] value,
  input  logic [OUT_W-1:0]   modulus,
  output logic [OUT_W-1:0]   residue_c
);

  localparam int unsigned MW = OUT_W + 1;
  localparam int unsigned AW = OUT_W + 2;

  logic [MW-1:0] m_eff;

  assign m_eff = (modulus == '0) ? {1'b1, {OUT_W{1'b0}}} : MW'(modulus);

  // Sum of (2^i mod m) over the set bits, kept below m after every addition.
  always_comb begin
    logic [AW-1:0] pow;
    logic [AW-1:0] acc;
    logic [AW-1:0] m_ext;
    m_ext = AW'(m_eff);
    pow   = (m_eff == MW'(1)) ? '0 : AW'(1);
    acc   = '0;
    for (int i = 0; i < STATE_W; i++) begin
      if (value[i]) begin
        acc = acc + pow;
        if (acc >= m_ext) acc = acc - m_ext;
      end
      pow = pow << 1;
      if (pow >= m_ext) pow = pow - m_ext;
    end
    residue_c = OUT_W'(acc);
  end

endmodule

// File: rtl/prn_sequence_gen.sv
// Burst generator of xorshift values reduced into [0, m-1] over a valid/ready stream.
// Define PRN_UNIQUE_EN to build the distinct-value (used bitmap) mode.
module prn_sequence_gen
  import prn_pkg::*;
#(
  parameter int unsigned STATE_W = 32,
  parameter int unsigned OUT_W   = 4,
  parameter int unsigned LEN_W   = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [STATE_W-1:0] seed_i,
  input  logic               seed_load_i,
  input  logic [OUT_W-1:0]   modulus_i,
  input  logic [LEN_W-1:0]   len_i,
  input  logic               uniq_i,
  input  logic               start_i,
  output logic               busy_o,
  output logic [OUT_W-1:0]   prn_o,
  output logic               prn_valid_o,
  input  logic               prn_ready_i,
  output logic               last_o,
  output logic               done_o,
  output logic               err_o
);

  localparam logic [STATE_W-1:0] SEED_RST = STATE_W'(DEFAULT_SEED);

  prn_state_e         state_q, state_d;
  logic [STATE_W-1:0] xs_q, xs_d, xs_next;
  logic [OUT_W-1:0]   m_q, m_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]   prn_d;
  logic               valid_d, last_d, done_d, err_d, busy_d;
  logic [OUT_W-1:0]   cand;
  logic               accept;

`ifdef PRN_UNIQUE_EN
  localparam int unsigned NV = 1 << OUT_W;
  localparam int unsigned MW = OUT_W + 1;
  localparam int unsigned CW = (LEN_W > MW) ? LEN_W : MW;

  logic          uniq_q, uniq_d;
  logic [NV-1:0] used_q, used_d;
  logic [CW-1:0] start_m;

  assign start_m = (modulus_i == '0) ? CW'(NV) : CW'(modulus_i);
  assign accept  = !(uniq_q && used_q[cand]);
`else
  logic unused_uniq;

  assign unused_uniq = uniq_i;
  assign accept      = 1'b1;
`endif

  assign xs_next = STATE_W'(xorshift_step(64'(xs_q), STATE_W));

  prn_mod_reduce #(
    .STATE_W (STATE_W),
    .OUT_W   (OUT_W)
  ) u_reduce (
    .value     (xs_next),
    .modulus   (m_q),
    .residue_c (cand)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    xs_d    = xs_q;
    m_d     = m_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    prn_d   = prn_o;
    valid_d = prn_valid_o;
    last_d  = last_o;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef PRN_UNIQUE_EN
    uniq_d  = uniq_q;
    used_d  = used_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (seed_load_i) begin
          xs_d = (seed_i == '0) ? SEED_RST : seed_i;
        end else if (start_i) begin
          m_d   = modulus_i;
          len_d = len_i;
          cnt_d = '0;
`ifdef PRN_UNIQUE_EN
          uniq_d = uniq_i;
          used_d = '0;
`endif
          if (len_i == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
`ifdef PRN_UNIQUE_EN
          else if (uniq_i && (CW'(len_i) > start_m)) begin
            err_d = 1'b1;
          end
`endif
          else begin
            state_d = ST_GEN;
          end
        end
      end

      // State advances every GEN cycle; a rejected candidate just retries.
      ST_GEN: begin
        xs_d = xs_next;
        if (accept) begin
          prn_d   = cand;
          last_d  = (cnt_q == (len_q - LEN_W'(1)));
          valid_d = 1'b1;
          state_d = ST_HOLD;
`ifdef PRN_UNIQUE_EN
          used_d[cand] = 1'b1;
`endif
        end
      end

      ST_HOLD: begin
        if (prn_ready_i) begin
          cnt_d   = cnt_q + LEN_W'(1);
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (last_o) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_GEN;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      xs_q        <= SEED_RST;
      m_q         <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      prn_o       <= '0;
      prn_valid_o <= 1'b0;
      last_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      busy_o      <= 1'b0;
`ifdef PRN_UNIQUE_EN
      uniq_q      <= 1'b0;
      used_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      xs_q        <= xs_d;
      m_q         <= m_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      prn_o       <= prn_d;
      prn_valid_o <= valid_d;
      last_o      <= last_d;
      done_o      <= done_d;
      err_o       <= err_d;
      busy_o      <= busy_d;
`ifdef PRN_UNIQUE_EN
      uniq_q      <= uniq_d;
      used_q      <= used_d;
`endif
    end
  end

endmodule
